raster_fb_writer: RTL
=====================

Name: raster_fb_writer

Overview:
- Consumer end of the rasterizer pixel stream: accepts (x,y) coordinates plus a fill colour from the triangle rasterizer.
- Clips each pixel to the framebuffer, converts it to a linear address y*FB_W+x and buffers it in a small FIFO.
- Drains the FIFO to framebuffer memory over a req/ack write port.
- Signals end-of-primitive once every accepted pixel of a triangle has been written.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- ADDR_W, 17, memory address width; must satisfy FB_W*FB_H <= 2^ADDR_W.
- COLOR_W, 16, pixel colour width.
- DEPTH, 4, write FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel present on pix_x/pix_y/pix_color.
- pix_ready  out  1  block can accept a pixel this cycle.
- pix_x  in  16  pixel column, unsigned.
- pix_y  in  16  pixel row, unsigned.
- pix_color  in  COLOR_W  pixel colour.
- tri_done  in  1  one-cycle pulse: no more pixels for the current triangle.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  COLOR_W  write data.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  pixels are pending in the stage register, the FIFO or the memory port.
- prim_done  out  1  one-cycle pulse: current triangle fully written.
- clip_cnt  out  16  count of pixels dropped by clipping since reset.

Behaviour:
- Reset state (asynchronous, immediate):
  - mem_req=0, mem_addr=0, mem_data=0.
  - prim_done=0, busy=0, clip_cnt=0.
  - FIFO empty, stage register invalid, tri_done latch cleared.
  - An in-flight request is abandoned; any mem_ack arriving during or after reset is ignored.
- Input handshake:
  - A pixel transfers on a rising edge where pix_valid & pix_ready.
  - pix_ready = (fifo_count + stage_valid) < DEPTH. It is combinational from internal state only, never from pix_valid.
- Stage 1 (clip and address), 1 cycle:
  - A transferred pixel is clipped if pix_x >= FB_W or pix_y >= FB_H. This covers sentinel coordinates such as 9999.
  - Clipped pixel: clip_cnt increments, saturating at 16'hFFFF; nothing is stored.
  - Unclipped pixel: the stage register captures addr = pix_y*FB_W + pix_x, truncated to ADDR_W, together with the colour.
- Stage 2 (FIFO push): the stage register pushes into the FIFO on the next edge. Push and pop in the same cycle are legal at any occupancy, including full.
- Memory FSM, states IDLE and REQ:
  - IDLE: if the FIFO is not empty, pop the head into mem_addr/mem_data, set mem_req=1 and go to REQ.
  - REQ: mem_req, mem_addr and mem_data stay stable until mem_ack=1 is sampled.
    - On ack with FIFO not empty: pop the next entry, keep mem_req=1 and stay in REQ. This gives back-to-back writes, one per cycle, when ack is tied high.
    - On ack with FIFO empty: mem_req=0, go to IDLE.
  - mem_ack is ignored in IDLE.
- Minimum latency: pixel accepted at edge N -> mem_req high after edge N+2 with the correct address.
- Primitive completion:
  - tri_done sets a latch. tri_done is honoured in the same cycle as a final pixel transfer; that pixel belongs to the same triangle.
  - When the latch is set, the stage register is empty, the FIFO is empty and the FSM is in IDLE, prim_done pulses high for exactly 1 cycle and the latch clears.
  - tri_done with zero pixels accepted (or all pixels clipped) -> prim_done 1 cycle later.
  - A second tri_done while the latch is already set is merged into the first: only one prim_done pulse.
- busy = stage_valid | (fifo_count != 0) | mem_req.

Decomposition:
- Shared package raster_pkg holds:
  - The default FB_W, FB_H, ADDR_W and COLOR_W constants.
  - The FSM state encoding (ST_IDLE, ST_REQ).
  - A pixel-entry type {addr, color} of width ADDR_W+COLOR_W.
- One sub-module is natural: raster_wr_fifo, a synchronous FIFO with DEPTH entries, push/pop, full/empty and count outputs, asynchronous reset.
- The multiply by FB_W is a constant multiply and stays inline.

Test Plan:
- Single pixel (10,2), colour 16'hF800, mem_ack tied 1 -> one write of addr 650 (2*320+10), data F800. mem_req is high for exactly 1 cycle, 2 cycles after acceptance.
- Pixels (319,239), (320,5) and (5,9999), then tri_done -> one write of addr 76799. clip_cnt=2. prim_done pulses once, after that write's ack.
- Burst of 8 pixels (0..7,0) with mem_ack held 0 -> pix_ready drops once 4 pixels are buffered and mem_addr stays at 0. After ack is released, addresses 0..7 are written in order, back-to-back, with no duplicates or losses.
- mem_ack asserted only every 3rd cycle during a 6-pixel stream -> mem_addr/mem_data never change while mem_req is high without an ack.
- tri_done in the same cycle as the last of 3 pixels -> prim_done only after the third write is acked. tri_done alone while idle -> prim_done on the next cycle.
- rst asserted mid-burst with mem_req=1 -> mem_req, busy and clip_cnt go to 0 immediately, with no pending writes after release. The next pixel (1,1) writes addr 321.

Source files
------------

// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared constants and types for the raster framebuffer writer
package raster_pkg;

    localparam int FB_W_DEF    = 320;
    localparam int FB_H_DEF    = 240;
    localparam int ADDR_W_DEF  = 17;
    localparam int COLOR_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  addr;
        logic [COLOR_W_DEF-1:0] color;
    } pix_entry_t;

endpackage

// File: rtl/raster_wr_fifo.sv
// rtl/raster_wr_fifo.sv - synchronous write FIFO with count, async active-high reset
module raster_wr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the head slot in the same edge, so push at full is safe then
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/raster_fb_writer.sv
// rtl/raster_fb_writer.sv - clips rasterizer pixels, linearises addresses and drains
// them to framebuffer memory over a req/ack port, flagging end of each primitive.
module raster_fb_writer
    import raster_pkg::*;
#(
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [15:0]        pix_x,
    input  logic [15:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               tri_done,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ack,
    output logic               busy,
    output logic               prim_done,
    output logic [15:0]        clip_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + COLOR_W;

    logic               r_stg_valid;
    logic [ADDR_W-1:0]  r_stg_addr;
    logic [COLOR_W-1:0] r_stg_color;
    logic               r_tri_pend;
    logic [15:0]        r_clip_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [COLOR_W-1:0] r_mem_data;
    wr_state_t          r_state;
    wr_state_t          w_state_nxt;

    logic               w_accept;
    logic               w_clip;
    logic               w_keep;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_drained;
    logic [CNT_W-1:0]   w_count;
    logic [ENT_W-1:0]   w_head;
    logic [ADDR_W-1:0]  w_lin_addr;

    // Stage slot is counted so a pixel accepted now always finds FIFO room next edge
    assign pix_ready  = (int'(w_count) + int'(r_stg_valid)) < DEPTH;
    assign w_accept   = pix_valid & pix_ready;
    assign w_clip     = (int'(pix_x) >= FB_W) || (int'(pix_y) >= FB_H);
    assign w_keep     = w_accept & ~w_clip;
    assign w_lin_addr = ADDR_W'(pix_y) * ADDR_W'(FB_W) + ADDR_W'(pix_x);
    assign w_push     = r_stg_valid & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_addr  <= '0;
            r_stg_color <= '0;
            r_clip_cnt  <= '0;
        end else begin
            r_stg_valid <= w_keep;
            if (w_keep) begin
                r_stg_addr  <= w_lin_addr;
                r_stg_color <= pix_color;
            end
            if (w_accept && w_clip && r_clip_cnt != 16'hFFFF)
                r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    raster_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_stg_addr, r_stg_color}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (!w_empty) w_pop       = 1'b1;
                    else          w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) {r_mem_addr, r_mem_data} <= w_head;
        end
    end

    // A tri_done arriving during the completion pulse folds into that pulse
    assign w_drained = ~r_stg_valid & w_empty & (r_state == ST_IDLE);
    assign prim_done = r_tri_pend & w_drained;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tri_pend <= 1'b0;
        else     r_tri_pend <= prim_done ? 1'b0 : (r_tri_pend | tri_done);
    end

    assign mem_req  = (r_state == ST_REQ);
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign clip_cnt = r_clip_cnt;
    assign busy     = r_stg_valid | (w_count != '0) | mem_req;

endmodule
